// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch conditioning logic and the minigame.
// Also holds the per-bit debounce state type.
package board_pkg;

    localparam int CLK_HZ         = 50_000_000;
    localparam int SW_COUNT       = 10;
    localparam int DB_CYCLES_10MS = 500_000;
    localparam int DB_CNT_W       = 19;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser followed by a stability-counting debouncer.
// The next-state level and pulses are exported so the top can register reductions in step.
module debounce_bit
    import board_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_10MS,
    parameter int CNT_W     = DB_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_level_nxt,
    output logic o_rise_nxt,
    output logic o_fall_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // A mismatch on the terminal cycle itself falls into the bounce-back branch first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (r_s2 != r_level) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_PENDING: begin
                if (r_s2 == r_level) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_level_nxt = r_s2;
                    w_rise_nxt  = r_s2;
                    w_fall_nxt  = ~r_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_level_nxt = w_level_nxt;
    assign o_rise_nxt  = w_rise_nxt;
    assign o_fall_nxt  = w_fall_nxt;

endmodule

// File: rtl/spdt_debouncer.sv
// Conditions the raw slide switches for the minigame: per-bit sync + debounce, edge pulses,
// and an any-change strobe / all-low flag registered alongside the debounced levels.
module spdt_debouncer
    import board_pkg::*;
#(
    parameter int WIDTH     = SW_COUNT,
    parameter int DB_CYCLES = DB_CYCLES_10MS,
    parameter int CNT_W     = DB_CNT_W
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SPDT_RAW,
    output logic [WIDTH-1:0] SPDT,
    output logic [WIDTH-1:0] SPDT_RISE,
    output logic [WIDTH-1:0] SPDT_FALL,
    output logic             CHANGED,
    output logic             ALL_LOW
);

    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic             r_changed;
    logic             r_all_low;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .i_clk       (MCLK),
            .i_rst_n     (RESET_N),
            .i_raw       (SPDT_RAW[g]),
            .o_level     (SPDT[g]),
            .o_rise      (SPDT_RISE[g]),
            .o_fall      (SPDT_FALL[g]),
            .o_level_nxt (w_level_nxt[g]),
            .o_rise_nxt  (w_rise_nxt[g]),
            .o_fall_nxt  (w_fall_nxt[g])
        );
    end

    // Built from next-state values so both flags land in the same cycle as SPDT.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            r_changed <= 1'b0;
            r_all_low <= 1'b1;
        end else begin
            r_changed <= |(w_rise_nxt | w_fall_nxt);
            r_all_low <= (w_level_nxt == '0);
        end
    end

    assign CHANGED = r_changed;
    assign ALL_LOW = r_all_low;

endmodule
